// File: rtl/fir_seq_mac.sv
// fir_seq_mac: handshaked TAPS-tap FIR filter sharing one multiplier across taps.
module fir_seq_mac #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS = 3,
    localparam int OUT_W = DATA_W + COEF_W + $clog2(TAPS),
    localparam int ADDR_W = (TAPS > 2) ? $clog2(TAPS) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              COEF_WE,
    input  logic [ADDR_W-1:0] COEF_ADDR,
    input  logic [COEF_W-1:0] COEF_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [OUT_W-1:0]  OUT_DATA
);
    localparam int PROD_W = DATA_W + COEF_W;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] x [TAPS];
    logic [COEF_W-1:0] coef [TAPS];
    logic [OUT_W-1:0]  acc;
    logic [OUT_W-1:0]  sum;
    logic [PROD_W-1:0] prod;
    logic [ADDR_W-1:0] idx;
    logic              last;
    logic              accept;
    logic              coef_wr;

    assign prod    = PROD_W'(coef[idx]) * PROD_W'(x[idx]);
    assign sum     = acc + OUT_W'(prod);
    assign last    = idx == ADDR_W'(TAPS - 1);
    assign accept  = IN_VALID && IN_READY;
    assign coef_wr = (state == IDLE) && COEF_WE && (32'(COEF_ADDR) < TAPS);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = (state == IDLE && IN_VALID)  ? MAC  :
                     (state == MAC  && last)      ? OUT  :
                     (state == OUT  && OUT_READY) ? IDLE : state;
    end

    always_comb begin
        IN_READY = (state == IDLE) && !RST;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < TAPS; k++) begin
                x[k]    <= '0;
                coef[k] <= COEF_W'(k + 1);
            end
            acc       <= '0;
            idx       <= '0;
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
        end else begin
            // a write landing with an accept is visible to that sample's MAC pass
            if (coef_wr) coef[COEF_ADDR] <= COEF_DATA;
            if (accept) begin
                for (int k = TAPS - 1; k > 0; k--) x[k] <= x[k-1];
                x[0] <= IN_DATA;
                acc  <= '0;
                idx  <= '0;
            end
            if (state == MAC) begin
                acc <= sum;
                idx <= idx + 1'b1;
                if (last) begin
                    OUT_DATA  <= sum;
                    OUT_VALID <= 1'b1;
                end
            end
            if (state == OUT && OUT_READY) OUT_VALID <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fir_seq_mac.sv
// tb_fir_seq_mac: randomized check of fir_seq_mac against a sum-of-products model.
module tb_fir_seq_mac;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        coef_we;
    logic [1:0]  coef_addr;
    logic [7:0]  coef_data;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_data;

    int total = 0;
    int bad = 0;

    logic [7:0] hx [3];
    logic [7:0] mc [3];

    fir_seq_mac dut (
        .CLK(clk), .RST(rst),
        .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data),
        .COEF_WE(coef_we), .COEF_ADDR(coef_addr), .COEF_DATA(coef_data),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_y();
        logic [31:0] s = 0;
        for (int k = 0; k < 3; k++) s += 32'(mc[k]) * 32'(hx[k]);
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            hx[k] = 8'd0;
            mc[k] = 8'(k + 1);
        end
    endtask

    task automatic wcoef(input logic [1:0] a, input logic [7:0] d);
        coef_we = 1'b1;
        coef_addr = a;
        coef_data = d;
        step();
        coef_we = 1'b0;
        if (a < 2'd3) mc[a] = d;
    endtask

    task automatic send(input logic [7:0] d, input int bp, input bit we, input logic [1:0] wa,
                        input logic [7:0] wd, input bit mac_we);
        int n;
        logic [31:0] e;
        logic [17:0] held;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        chk("accept_wait", n, 0);
        in_valid = 1'b1;
        in_data = d;
        coef_we = we;
        coef_addr = wa;
        coef_data = wd;
        if (bp > 0) out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        coef_we = 1'b0;
        if (we && wa < 2'd3) mc[wa] = wd;
        hx[2] = hx[1];
        hx[1] = hx[0];
        hx[0] = d;
        e = model_y();
        chk("busy_ready", in_ready, 0);
        if (mac_we) begin
            coef_we = 1'b1;
            coef_addr = 2'd0;
            coef_data = ~mc[0];
        end
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        coef_we = 1'b0;
        chk("latency", n, 3);
        chk("result", out_data, e);
        if (bp > 0) begin
            in_valid = 1'b1;
            in_data = 8'($urandom);
            held = out_data;
            repeat (bp) begin
                step();
                chk("bp_valid", out_valid, 1);
                chk("bp_data", out_data, held);
                chk("bp_ready", in_ready, 0);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        step();
        chk("taken", out_valid, 0);
        chk("idle_ready", in_ready, 1);
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        #3;
        chk("rst_ready", in_ready, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        step();
        rst = 1'b0;
        #1;
        chk("rel_ready", in_ready, 1);
        model_reset();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'd0;
        coef_we = 1'b0;
        coef_addr = 2'd0;
        coef_data = 8'd0;
        out_ready = 1'b1;
        model_reset();
        repeat (2) step();
        rst_pulse();

        send(8'd10, 0, 0, 0, 0, 0);
        chk("plan_10", out_data, 10);
        send(8'd20, 0, 0, 0, 0, 0);
        chk("plan_40", out_data, 40);
        send(8'd30, 0, 0, 0, 0, 0);
        chk("plan_100", out_data, 100);

        rst_pulse();
        wcoef(2'd0, 8'd0);
        wcoef(2'd1, 8'd0);
        wcoef(2'd2, 8'd4);
        send(8'd5, 0, 0, 0, 0, 0);
        send(8'd0, 0, 0, 0, 0, 0);
        send(8'd0, 0, 0, 0, 0, 0);
        chk("plan_20", out_data, 20);

        rst_pulse();
        send(8'd10, 10, 0, 0, 0, 0);
        send(8'd20, 0, 0, 0, 0, 1);
        wcoef(2'd3, 8'd77);
        send(8'd30, 0, 0, 0, 0, 1);
        chk("ignored_wr", out_data, 100);

        in_valid = 1'b1;
        in_data = 8'd99;
        step();
        in_valid = 1'b0;
        step();
        #2;
        rst_pulse();
        repeat (6) begin
            step();
            chk("no_partial", out_valid, 0);
        end
        send(8'd7, 0, 0, 0, 0, 0);
        chk("after_rst", out_data, 7);

        send(8'd3, 0, 1, 2'd1, 8'd50, 0);

        wcoef(2'd0, 8'd255);
        wcoef(2'd1, 8'd255);
        wcoef(2'd2, 8'd255);
        repeat (3) send(8'd255, 0, 0, 0, 0, 0);
        chk("full_scale", out_data, 195075);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) wcoef(2'($urandom_range(0, 3)), 8'($urandom));
            send(8'($urandom),
                 ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : 0,
                 $urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)), 8'($urandom),
                 $urandom_range(0, 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
